// File: rtl/spi_master_param.sv
// Full-duplex SPI master: DATA_W-bit words, CLK_DIV-scaled SCLK, four CPOL/CPHA modes, MSB/LSB first.
// done arrives 1+CLK_DIV*(2*DATA_W+2) cycles after start is accepted; start is ignored outside IDLE.
module spi_master_param #(
  parameter  int DATA_W  = 8,
  parameter  int CLK_DIV = 4,
  parameter  int SEL_W   = 2,
  localparam int NUM_CS  = 2**SEL_W,
  localparam int CNT_W   = $clog2(DATA_W+1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [SEL_W-1:0]  cs_sel,
  input  logic [DATA_W-1:0] data_wr,
  input  logic              miso,
  output logic              spi_clk,
  output logic [NUM_CS-1:0] cs_n,
  output logic              mosi,
  output logic [DATA_W-1:0] data_rd,
  output logic              busy,
  output logic              done,
  output logic [2:0]        state,
  output logic [CNT_W-1:0]  count
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EDGE_W = $clog2(2*DATA_W);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    XFER  = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_cnt;
  logic [EDGE_W-1:0]   edge_cnt;
  logic                cpol_q, cpha_q, lsb_q;
  logic [DATA_W-1:0]   tx_q, rx_q, rd_q;
  logic                sclk_q, mosi_q;
  logic [NUM_CS-1:0]   cs_n_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                active, tick, last_edge, sample_ev, drive_ev;

  function automatic logic head(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? {1'b0, w[DATA_W-1:1]} : {w[DATA_W-2:0], 1'b0};
  endfunction

  assign active    = (state_q == SETUP) || (state_q == XFER) || (state_q == HOLD);
  assign tick      = (div_cnt == DIV_W'(CLK_DIV-1));
  assign last_edge = (edge_cnt == EDGE_W'(2*DATA_W-1));
  // Even edge_cnt values are leading SCLK edges, odd ones trailing.
  assign sample_ev = (state_q == XFER) && tick && (edge_cnt[0] == cpha_q);
  assign drive_ev  = (state_q == XFER) && tick &&
                     (cpha_q ? !edge_cnt[0] : (edge_cnt[0] && !last_edge));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SETUP;
      SETUP:   if (tick) state_d = XFER;
      XFER:    if (tick && last_edge) state_d = HOLD;
      HOLD:    if (tick) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt  <= '0;
      edge_cnt <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      lsb_q    <= 1'b0;
      tx_q     <= '0;
      rx_q     <= '0;
      rd_q     <= '0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      cs_n_q   <= '1;
      cnt_q    <= '0;
    end else begin
      if (active) div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
      else        div_cnt <= '0;

      if (state_q != XFER) edge_cnt <= '0;
      else if (tick)       edge_cnt <= edge_cnt + EDGE_W'(1);

      if (state_q == IDLE && start) begin
        cpol_q <= cpol;
        cpha_q <= cpha;
        lsb_q  <= lsb_first;
        sclk_q <= cpol;
        cs_n_q <= ~(NUM_CS'(1) << cs_sel);
        cnt_q  <= '0;
        rx_q   <= '0;
        // With cpha=0 the first bit must be on mosi before the first leading edge.
        if (!cpha) begin
          mosi_q <= head(data_wr, lsb_first);
          tx_q   <= shift(data_wr, lsb_first);
        end else begin
          tx_q   <= data_wr;
        end
      end

      if (state_q == XFER && tick) sclk_q <= ~sclk_q;

      if (drive_ev) begin
        mosi_q <= head(tx_q, lsb_q);
        tx_q   <= shift(tx_q, lsb_q);
      end

      if (sample_ev) begin
        rx_q  <= lsb_q ? {miso, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], miso};
        cnt_q <= cnt_q + CNT_W'(1);
      end

      if (state_q == HOLD && tick) begin
        cs_n_q <= '1;
        rd_q   <= rx_q;
      end
    end
  end

  assign spi_clk = sclk_q;
  assign cs_n    = cs_n_q;
  assign mosi    = mosi_q;
  assign data_rd = rd_q;
  assign busy    = active;
  assign done    = (state_q == DONE);
  assign state   = state_q;
  assign count   = cnt_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench for spi_master_param: table of mode/data vectors plus reset, re-start and back-to-back sequences.
module tb_spi_master_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, cpol, cpha, lsb_first, miso;
  logic [1:0] cs_sel;
  logic [7:0] data_wr, data_rd;
  logic       spi_clk, mosi, busy, done;
  logic [3:0] cs_n, count;
  logic [2:0] state;
  logic       loop_en, slave_miso;

  assign miso = loop_en ? mosi : slave_miso;

  spi_master_param #(.DATA_W(8), .CLK_DIV(4), .SEL_W(2)) u_dut (
    .clk(clk), .reset(rst_n), .start(start), .cpol(cpol), .cpha(cpha),
    .lsb_first(lsb_first), .cs_sel(cs_sel), .data_wr(data_wr), .miso(miso),
    .spi_clk(spi_clk), .cs_n(cs_n), .mosi(mosi), .data_rd(data_rd),
    .busy(busy), .done(done), .state(state), .count(count)
  );

  logic        start2, cpol2, cpha2, lsb2, miso2, spi_clk2, mosi2, busy2, done2;
  logic [1:0]  cs_sel2;
  logic [15:0] data_wr2, data_rd2;
  logic [3:0]  cs_n2;
  logic [2:0]  state2;
  logic [4:0]  count2;

  assign miso2 = mosi2;

  spi_master_param #(.DATA_W(16), .CLK_DIV(1), .SEL_W(2)) u_dut16 (
    .clk(clk), .reset(rst_n), .start(start2), .cpol(cpol2), .cpha(cpha2),
    .lsb_first(lsb2), .cs_sel(cs_sel2), .data_wr(data_wr2), .miso(miso2),
    .spi_clk(spi_clk2), .cs_n(cs_n2), .mosi(mosi2), .data_rd(data_rd2),
    .busy(busy2), .done(done2), .state(state2), .count(count2)
  );

  typedef struct {
    logic       cpol;
    logic       cpha;
    logic       lsb;
    logic [1:0] cs;
    logic [7:0] dw;
    logic       loop;
    logic [7:0] sw;
    logic [7:0] exp_rd;
    logic [3:0] exp_cs;
    logic       exp_first;
    int         reissue;
  } vec_t;

  vec_t vecs[7];
  int   checks, errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int k, input vec_t v);
    int         lat, rises, nbits, drv, cs_bad, dones;
    logic       got, first, pclk, pbusy, d_clk, d_busy;
    logic [3:0] bad_cs, d_cs, d_cnt;
    logic [7:0] cap;
    lat = 0; rises = 0; nbits = 0; drv = 0; cs_bad = 0; dones = 0;
    got = 1'b0; first = 1'b0; bad_cs = 4'h0; cap = 8'h00;
    d_clk = 1'b0; d_busy = 1'b1; d_cs = 4'h0; d_cnt = 4'h0;
    @(negedge clk);
    cpol = v.cpol; cpha = v.cpha; lsb_first = v.lsb; cs_sel = v.cs;
    data_wr = v.dw; loop_en = v.loop; slave_miso = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pbusy = 1'b0; pclk = spi_clk;
    for (int i = 0; i < 300; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      if (v.reissue == i) begin start = 1'b1; data_wr = 8'hFF; end
      else if (v.reissue + 1 == i) start = 1'b0;
      if (busy && cs_n !== v.exp_cs) begin cs_bad++; bad_cs = cs_n; end
      if (busy && pbusy && spi_clk !== pclk) begin
        if (spi_clk) rises++;
        // Slave samples on rising edges when cpol==cpha, falling otherwise; drives on the other edge.
        if (spi_clk == (v.cpol == v.cpha)) begin
          if (nbits == 0) first = mosi;
          cap = v.lsb ? {mosi, cap[7:1]} : {cap[6:0], mosi};
          nbits++;
        end else if (drv < 8) begin
          slave_miso = v.sw[7-drv];
          drv++;
        end
      end
      pbusy = busy; pclk = spi_clk;
      if (done) begin
        got = 1'b1; lat = i + 1; dones++;
        d_clk = spi_clk; d_busy = busy; d_cs = cs_n; d_cnt = count;
        break;
      end
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    chk($sformatf("v%0d_done_seen", k), 32'(got), 32'd1);
    chk($sformatf("v%0d_latency", k), 32'(lat), 32'd73);
    chk($sformatf("v%0d_data_rd", k), 32'(data_rd), 32'(v.exp_rd));
    chk($sformatf("v%0d_rises", k), 32'(rises), 32'd8);
    chk($sformatf("v%0d_cs_n_bad_cycles(last=%0h)", k, bad_cs), 32'(cs_bad), 32'd0);
    chk($sformatf("v%0d_slave_cap", k), 32'(cap), 32'(v.dw));
    chk($sformatf("v%0d_first_mosi", k), 32'(first), 32'(v.exp_first));
    chk($sformatf("v%0d_idle_sclk", k), 32'(d_clk), 32'(v.cpol));
    chk($sformatf("v%0d_done_cs_n", k), 32'(d_cs), 32'hF);
    chk($sformatf("v%0d_done_busy", k), 32'(d_busy), 32'd0);
    chk($sformatf("v%0d_count", k), 32'(d_cnt), 32'd8);
    chk($sformatf("v%0d_done_pulses", k), 32'(dones), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat, gap, idle_cnt;
    logic got;
    checks = 0; errors = 0;
    vecs[0] = '{1'b0, 1'b0, 1'b0, 2'd0, 8'hC3, 1'b1, 8'h00, 8'hC3, 4'b1110, 1'b1, -1};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 2'd0, 8'hAB, 1'b1, 8'h00, 8'hAB, 4'b1110, 1'b1, -1};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 2'd2, 8'h3A, 1'b0, 8'h5C, 8'h5C, 4'b1011, 1'b0, -1};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 2'd1, 8'h01, 1'b1, 8'h00, 8'h01, 4'b1101, 1'b1, -1};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 2'd3, 8'h01, 1'b1, 8'h00, 8'h01, 4'b0111, 1'b1, -1};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 2'd1, 8'h96, 1'b1, 8'h00, 8'h96, 4'b1101, 1'b0, -1};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 2'd0, 8'hAB, 1'b1, 8'h00, 8'hAB, 4'b1110, 1'b1, 19};

    rst_n = 1'b0; start = 1'b0; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
    cs_sel = 2'd0; data_wr = 8'h00; loop_en = 1'b1; slave_miso = 1'b0;
    start2 = 1'b0; cpol2 = 1'b0; cpha2 = 1'b0; lsb2 = 1'b0; cs_sel2 = 2'd0; data_wr2 = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_cs_n", 32'(cs_n), 32'hF);
    chk("rst_spi_clk", 32'(spi_clk), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_data_rd", 32'(data_rd), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset asserted in the middle of a transfer.
    @(negedge clk);
    data_wr = 8'h5A; loop_en = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (39) @(posedge clk);
    #1;
    chk("mid_state_xfer", 32'(state), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cs_n", 32'(cs_n), 32'hF);
    chk("mid_rst_spi_clk", 32'(spi_clk), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_data_rd", 32'(data_rd), 32'd0);
    chk("mid_rst_state", 32'(state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 7; k++) run_vec(k, vecs[k]);

    // DATA_W=16, CLK_DIV=1 with start held high: two back-to-back loopback transfers.
    @(negedge clk);
    data_wr2 = 16'hBEEF; start2 = 1'b1;
    @(posedge clk); #1;
    got = 1'b0; lat = 0;
    for (int i = 0; i < 100; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      if (done2) begin got = 1'b1; lat = i + 1; break; end
    end
    chk("b2b_first_done_seen", 32'(got), 32'd1);
    chk("b2b_first_latency", 32'(lat), 32'd35);
    chk("b2b_first_data_rd", 32'(data_rd2), 32'hBEEF);
    got = 1'b0; gap = 0; idle_cnt = 0;
    for (int i = 1; i < 100; i++) begin
      @(posedge clk); #1;
      if (state2 == 3'd0) idle_cnt++;
      if (done2) begin got = 1'b1; gap = i; break; end
    end
    chk("b2b_second_done_seen", 32'(got), 32'd1);
    chk("b2b_done_gap", 32'(gap), 32'd36);
    chk("b2b_idle_cycles", 32'(idle_cnt), 32'd1);
    chk("b2b_second_data_rd", 32'(data_rd2), 32'hBEEF);
    @(negedge clk);
    start2 = 1'b0;
    repeat (5) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_master_param.md
Name: spi_master_param

Overview:
Parametrised full-duplex SPI master, the successor to the fixed 8-bit, single-slave, mode-0 master.
- Generic word width, programmable SCLK divider, all four CPOL/CPHA modes, MSB- or LSB-first shifting, and up to 2**SEL_W chip selects.
- Uses a start/busy/done handshake, returns received data on data_rd, and exposes state/count for debug.
- Sits between a system-clock register/control block and external SPI slaves.

Parameters:
- DATA_W, 8: bits per transfer (2..32).
- CLK_DIV, 4: clk cycles per SCLK half-period (>=1).
- SEL_W, 2: chip-select index width; NUM_CS = 2**SEL_W lines.
- CNT_W (localparam), $clog2(DATA_W+1): width of count.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  transfer request; sampled only in IDLE.
- cpol  in  1  SCLK idle level; latched at start.
- cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge; latched at start.
- lsb_first  in  1  1 = LSB shifted first; latched at start.
- cs_sel  in  SEL_W  target slave index; latched at start.
- data_wr  in  DATA_W  transmit word; latched at start.
- miso  in  1  serial data from slave.
- spi_clk  out  1  SCLK.
- cs_n  out  NUM_CS  active-low chip selects; at most one low.
- mosi  out  1  serial data to slave.
- data_rd  out  DATA_W  received word; valid from the done pulse until the next done.
- busy  out  1  high from the cycle after start acceptance through HOLD.
- done  out  1  one-cycle pulse at transfer end.
- state  out  3  FSM encoding: IDLE=0, SETUP=1, XFER=2, HOLD=3, DONE=4.
- count  out  CNT_W  bits sampled so far in the current transfer.

Behaviour:
- Reset (async, reset=0):
  - state=IDLE, cs_n=all 1, spi_clk=0, mosi=0, data_rd=0, busy=0, done=0, count=0.
  - Latched cpol=0, cpha=0, lsb_first=0.
  - Takes effect immediately, including mid-transfer; no partial data_rd update.
- IDLE:
  - spi_clk = latched cpol.
  - start=1 at posedge: latch data_wr and mode inputs, go to SETUP.
- SETUP (CLK_DIV cycles):
  - cs_n[cs_sel]=0, busy=1, spi_clk idle.
  - If cpha=0, mosi carries the first bit: bit DATA_W-1, or bit 0 when lsb_first=1.
- XFER (2*DATA_W*CLK_DIV cycles):
  - spi_clk toggles every CLK_DIV cycles, giving DATA_W full periods.
  - cpha=0: sample miso on each leading edge; drive next mosi bit on each trailing edge except the last.
  - cpha=1: drive mosi on each leading edge; sample miso on each trailing edge.
  - count increments on each sample and reaches DATA_W at the last sample.
  - Receive shift direction mirrors transmit, so the first received bit lands at the MSB (lsb_first=0) or LSB (lsb_first=1).
- HOLD (CLK_DIV cycles):
  - spi_clk idle, cs_n still asserted, mosi holds the last bit.
- DONE (1 cycle):
  - cs_n all high, busy=0, done=1, data_rd loaded with the receive shift register.
  - Next state: IDLE.
- Latency:
  - With start sampled at edge T, cs_n falls after edge T.
  - done is high in cycle T+1+CLK_DIV*(2*DATA_W+2). Defaults: 73 cycles.
- Handshake and input changes:
  - start is ignored while busy or in DONE.
  - If start is held high, the next transfer is accepted in the IDLE cycle after DONE.
  - Changes to mode, cs_sel or data_wr during a transfer have no effect.
- Divider counter:
  - Counts 0..CLK_DIV-1 and wraps.
  - With CLK_DIV=1, SCLK toggles every clk cycle.

Test Plan:
- Mode 0, MSB first, data_wr=8'hAB, miso tied to mosi, cs_sel=0 -> data_rd=8'hAB.
  - done exactly 73 cycles after start.
  - cs_n=4'b1110 during the transfer.
  - 8 rising edges on spi_clk.
- Mode 3 (cpol=1, cpha=1), slave model returning 8'h5C, data_wr=8'h3A, cs_sel=2:
  - spi_clk idles high.
  - Slave captures 8'h3A on rising edges.
  - data_rd=8'h5C; only cs_n[2] is low.
- Mode 1 and mode 2 with lsb_first=1, data_wr=8'h01 -> first mosi bit is 1, then 7 zeros; loopback gives data_rd=8'h01.
- start pulsed again at cycle 20 of a transfer, with data_wr changed to 8'hFF:
  - Ignored; the original word completes; exactly one done pulse.
- reset driven low at cycle 40 of a transfer:
  - Immediately cs_n=all 1, spi_clk=0, busy=0, data_rd unchanged at 0.
  - After release, a fresh transfer of 8'hC3 completes correctly.
- Parameter sweep DATA_W=16, CLK_DIV=1, start held high:
  - Two back-to-back loopback transfers (16'hBEEF) each take 1+1*34=35 cycles to done.
  - One IDLE cycle separates them.
